// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: byte FIFO, receiver drain handshake, baud generator, register port
// Define RX_OVERRUN_DROP_EN to acknowledge and drop bytes arriving at a full FIFO and flag overrun.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_AW   = 2,
  parameter logic [15:0] DIV_RESET = 16'd325
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iocs,
  input  logic               iorw,
  input  logic [1:0]         ioaddr,
  input  logic [7:0]         databus_in,
  output logic [7:0]         databus_out,
  input  logic [7:0]         rx_data,
  input  logic               rx_rda,
  output logic               rx_ack,
  output logic               r_enable,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overrun
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_GUARD} state_e;

  state_e               state_q;
  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [15:0]          div_q, div_d, cnt_q, cnt_d;
  logic                 rx_ack_q, r_en_q;
  logic                 full, nonempty, pop, push, go_ack, stat_rd, div_wr, ovr;

  always_comb begin
    full     = (count_q == DEPTH_C);
    nonempty = (count_q != '0);
    pop      = iocs && iorw && (ioaddr == 2'b00) && nonempty;
    stat_rd  = iocs && iorw && (ioaddr == 2'b01);
    div_wr   = iocs && !iorw && ioaddr[1];
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    push     = (state_q == S_IDLE) && rx_rda && (!full || pop);
  end

`ifdef RX_OVERRUN_DROP_EN
  logic drop;
  logic overrun_q;

  assign drop   = (state_q == S_IDLE) && rx_rda && full && !pop;
  assign go_ack = push || drop;
  assign ovr    = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (stat_rd) begin
      overrun_q <= 1'b0;
    end
  end
`else
  assign go_ack = push;
  assign ovr    = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (FIFO_AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (FIFO_AW + 1)'(1);
    end

    div_d = div_q;
    if (div_wr) begin
      if (ioaddr[0]) div_d[15:8] = databus_in;
      else           div_d[7:0]  = databus_in;
    end

    if (div_wr)              cnt_d = div_d;
    else if (cnt_q == 16'd0) cnt_d = div_q;
    else                     cnt_d = cnt_q - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rx_ack_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      div_q    <= DIV_RESET;
      cnt_q    <= DIV_RESET;
      r_en_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_ack) begin
            state_q  <= S_ACK;
            rx_ack_q <= 1'b1;
          end
        end
        S_ACK: begin
          state_q  <= S_GUARD;
          rx_ack_q <= 1'b0;
        end
        S_GUARD: state_q <= S_IDLE;
        default: begin
          state_q  <= S_IDLE;
          rx_ack_q <= 1'b0;
        end
      endcase

      if (push) begin
        mem_q[wr_ptr_q] <= rx_data;
        wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      count_q <= count_d;

      div_q  <= div_d;
      cnt_q  <= cnt_d;
      // r_enable mirrors counter==0, except it is held low right after a divisor reload.
      r_en_q <= !div_wr && (cnt_d == 16'd0);
    end
  end

  always_comb begin
    databus_out = 8'h00;
    if (iocs && iorw) begin
      case (ioaddr)
        2'b00:   databus_out = nonempty ? mem_q[rd_ptr_q] : 8'h00;
        2'b01:   databus_out = {5'b0, ovr, full, nonempty};
        2'b10:   databus_out = div_q[7:0];
        default: databus_out = div_q[15:8];
      endcase
    end
  end

  assign rx_ack     = rx_ack_q;
  assign r_enable   = r_en_q;
  assign fifo_count = count_q;
  assign overrun    = ovr;

endmodule
